// File: rtl/uart_baud_gen_if.sv
// Control/status bundle for the UART baud tick generator.
// The master side issues control (enable, divisor load, resync).
// The slave side (the generator) returns tick strobes and status.
interface uart_baud_gen_if #(
  parameter int DIV_WIDTH  = 16,
  parameter int OVERSAMPLE = 16
);
  localparam int PH_W = $clog2(OVERSAMPLE);

  logic                 en;
  logic [DIV_WIDTH-1:0] div_in;
  logic                 div_load;
  logic                 resync;
  logic                 os_tick;
  logic                 baud_tick;
  logic [PH_W-1:0]      os_phase;
  logic [DIV_WIDTH-1:0] div_active;
  logic                 div_err;

  modport master (
    output en, div_in, div_load, resync,
    input  os_tick, baud_tick, os_phase, div_active, div_err
  );

  modport slave (
    input  en, div_in, div_load, resync,
    output os_tick, baud_tick, os_phase, div_active, div_err
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Baud-rate tick generator for the UART datapath.
// Produces single-cycle enables rather than a derived clock:
//  - os_tick every div_active clocks, for RX oversampling.
//  - baud_tick once per OVERSAMPLE os_ticks, for TX shifting.
// A divisor change is held pending until a period boundary, so no period is cut short.
// resync restarts the prescaler with the phase at mid-bit, aligning sampling to an RX start edge.
module uart_baud_gen #(
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 27,
  parameter int OVERSAMPLE  = 16
) (
  input  logic              clk,
  input  logic              rst,
  uart_baud_gen_if.slave    bus
);

  localparam int PH_W = $clog2(OVERSAMPLE);

  localparam logic [DIV_WIDTH-1:0] DIV_RST   = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [PH_W-1:0]      PH_MID    = PH_W'(OVERSAMPLE / 2);
  localparam logic [PH_W-1:0]      PH_LAST   = PH_W'(OVERSAMPLE - 1);

  // A divisor below 2 would leave no room for a non-tick cycle.
  function automatic logic div_legal(input logic [DIV_WIDTH-1:0] d);
    return (d >= DIV_WIDTH'(2));
  endfunction

  logic [DIV_WIDTH-1:0] pc_q, pc_d;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] pend_q, pend_d;
  logic                 pend_vld_q, pend_vld_d;
  logic                 os_tick_q, os_tick_d;
  logic                 baud_tick_q, baud_tick_d;
  logic                 div_err_q, div_err_d;

  logic                 wrap_s;
  logic                 load_ok_s;
  logic                 apply_s;

  assign wrap_s    = (pc_q == (div_q - DIV_WIDTH'(1)));
  assign load_ok_s = bus.div_load & div_legal(bus.div_in);
  // Divisor changes are taken only where the current period is finished or abandoned.
  // That is: at a wrap, at resync, or while frozen, since no wrap will come while frozen.
  assign apply_s   = bus.resync | ~bus.en | wrap_s;

  // Prescaler, oversample phase and tick strobes.
  always_comb begin
    pc_d        = pc_q;
    phase_d     = phase_q;
    os_tick_d   = 1'b0;
    baud_tick_d = 1'b0;
    if (bus.resync) begin
      pc_d    = '0;
      phase_d = PH_MID;
    end else if (bus.en) begin
      if (wrap_s) begin
        pc_d        = '0;
        os_tick_d   = 1'b1;
        phase_d     = phase_q + PH_W'(1);
        baud_tick_d = (phase_q == PH_LAST);
      end else begin
        pc_d = pc_q + DIV_WIDTH'(1);
      end
    end else begin
      pc_d    = pc_q;
      phase_d = phase_q;
    end
  end

  // Divisor pending/apply logic and illegal-load reporting.
  always_comb begin
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    div_err_d  = bus.div_load & ~div_legal(bus.div_in);
    if (apply_s) begin
      // A load arriving on the boundary edge itself governs the very next period.
      if (load_ok_s) begin
        div_d      = bus.div_in;
        pend_vld_d = 1'b0;
      end else if (pend_vld_q) begin
        div_d      = pend_q;
        pend_vld_d = 1'b0;
      end else begin
        div_d      = div_q;
      end
    end else begin
      if (load_ok_s) begin
        pend_d     = bus.div_in;
        pend_vld_d = 1'b1;
      end else begin
        pend_d     = pend_q;
      end
    end
  end

  // State registers with synchronous reset overriding resync and pending loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= '0;
      phase_q     <= '0;
      div_q       <= DIV_RST;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      os_tick_q   <= 1'b0;
      baud_tick_q <= 1'b0;
      div_err_q   <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      phase_q     <= phase_d;
      div_q       <= div_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      os_tick_q   <= os_tick_d;
      baud_tick_q <= baud_tick_d;
      div_err_q   <= div_err_d;
    end
  end

  assign bus.os_tick    = os_tick_q;
  assign bus.baud_tick  = baud_tick_q;
  assign bus.os_phase   = phase_q;
  assign bus.div_active = div_q;
  assign bus.div_err    = div_err_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen.
// A countdown reference model predicts tick events and pushes them to a scoreboard.
// A separate monitor pops and compares whenever the DUT strobes.
module tb_uart_baud_gen;

  localparam int DW  = 16;
  localparam int DEF = 27;
  localparam int OS  = 16;

  logic clk = 1'b0;
  logic rst;

  uart_baud_gen_if #(.DIV_WIDTH(DW), .OVERSAMPLE(OS)) bus ();

  uart_baud_gen #(.DIV_WIDTH(DW), .DEFAULT_DIV(DEF), .OVERSAMPLE(OS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int phase;
    int baud;
    int div;
  } exp_t;

  exp_t tick_q[$];
  int   err_q[$];

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;
  bit chk_on  = 1'b0;

  // Reference state: clocks left in the current period rather than an up-counter.
  int m_div    = DEF;
  int m_left   = DEF;
  int m_phase  = 0;
  int m_pend   = 0;
  bit m_pend_v = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic apply_div(input bit legal);
    if (legal) begin
      m_div    = int'(bus.div_in);
      m_pend_v = 1'b0;
    end else if (m_pend_v) begin
      m_div    = m_pend;
      m_pend_v = 1'b0;
    end
  endtask

  // Behavioural reference model, evaluated at every active edge.
  initial begin : ref_model
    bit   legal;
    int   elapsed;
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_div    = DEF;
        m_left   = DEF;
        m_phase  = 0;
        m_pend_v = 1'b0;
      end else begin
        legal = bus.div_load && (bus.div_in >= 16'd2);
        if (bus.div_load && (bus.div_in < 16'd2)) err_q.push_back(cyc);
        if (bus.resync) begin
          apply_div(legal);
          m_left  = m_div;
          m_phase = OS / 2;
        end else if (bus.en) begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_phase = (m_phase + 1) % OS;
            apply_div(legal);
            m_left  = m_div;
            e.cyc   = cyc;
            e.phase = m_phase;
            e.baud  = (m_phase == 0) ? 1 : 0;
            e.div   = m_div;
            tick_q.push_back(e);
          end else if (legal) begin
            m_pend   = int'(bus.div_in);
            m_pend_v = 1'b1;
          end
        end else begin
          elapsed = m_div - m_left;
          apply_div(legal);
          m_left  = m_div - elapsed;
        end
      end
    end
  end

  // Monitor: compare DUT strobes and status against the model, away from the active edge.
  initial begin : monitor
    exp_t e;
    int   c;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        check("os_phase", 32'(bus.os_phase), 32'(m_phase));
        check("div_active", 32'(bus.div_active), 32'(m_div));
        if (bus.baud_tick === 1'b1 && bus.os_tick !== 1'b1) begin
          vectors++; fails++;
          $display("FAIL baud_alone: baud_tick=1 with os_tick=%b (cycle %0d)", bus.os_tick, cyc);
        end
        if (bus.os_tick === 1'b1) begin
          if (tick_q.size() == 0) begin
            vectors++; fails++;
            $display("FAIL unexpected_os_tick: got os_tick=1 expected none (cycle %0d)", cyc);
          end else begin
            e = tick_q.pop_front();
            check("tick_cycle", 32'(cyc), 32'(e.cyc));
            check("tick_phase", 32'(bus.os_phase), 32'(e.phase));
            check("tick_baud", 32'(bus.baud_tick), 32'(e.baud));
            check("tick_div", 32'(bus.div_active), 32'(e.div));
          end
        end else if (tick_q.size() > 0 && tick_q[0].cyc <= cyc) begin
          e = tick_q.pop_front();
          vectors++; fails++;
          $display("FAIL missed_os_tick: got none expected tick at cycle %0d (now %0d)", e.cyc, cyc);
        end
        if (bus.div_err === 1'b1) begin
          if (err_q.size() == 0) begin
            vectors++; fails++;
            $display("FAIL unexpected_div_err: got 1 expected 0 (cycle %0d)", cyc);
          end else begin
            c = err_q.pop_front();
            check("div_err_cycle", 32'(cyc), 32'(c));
          end
        end else if (err_q.size() > 0 && err_q[0] <= cyc) begin
          c = err_q.pop_front();
          vectors++; fails++;
          $display("FAIL missed_div_err: got 0 expected pulse at cycle %0d", c);
        end
      end
    end
  end

  task automatic wait_for(input bit want_baud, input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((want_baud ? bus.baud_tick : bus.os_tick) === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    vectors++;
    if (!seen) begin
      fails++;
      $display("FAIL wait_%s: got no strobe expected one within %0d cycles", want_baud ? "baud" : "os", limit);
    end
  endtask

  task automatic pulse_load(input logic [DW-1:0] v);
    bus.div_load = 1'b1;
    bus.div_in   = v;
    @(negedge clk);
    bus.div_load = 1'b0;
  endtask

  task automatic pulse_resync();
    bus.resync = 1'b1;
    @(negedge clk);
    bus.resync = 1'b0;
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin : driver
    int t0;
    int ph;
    int r;
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.div_in   = '0;
    bus.div_load = 1'b0;
    bus.resync   = 1'b0;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    check("rst_os_tick", 32'(bus.os_tick), 32'd0);
    check("rst_baud_tick", 32'(bus.baud_tick), 32'd0);
    check("rst_div_err", 32'(bus.div_err), 32'd0);
    check("rst_div_active", 32'(bus.div_active), 32'd27);
    check("rst_os_phase", 32'(bus.os_phase), 32'd0);

    // Free-running from reset release with the default divisor.
    bus.en = 1'b1;
    rst    = 1'b0;
    t0     = cyc;
    wait_for(1'b0, 100);
    check("first_os_tick_delay", 32'(cyc - t0), 32'd27);
    wait_for(1'b1, 1000);
    check("first_baud_delay", 32'(cyc - t0), 32'd432);
    check("baud_phase", 32'(bus.os_phase), 32'd0);

    // Resync at an arbitrary point.
    repeat (7) @(negedge clk);
    pulse_resync();
    check("resync_no_tick", 32'(bus.os_tick), 32'd0);
    check("resync_phase", 32'(bus.os_phase), 32'd8);
    t0 = cyc;
    wait_for(1'b0, 100);
    check("resync_os_delay", 32'(cyc - t0), 32'd27);
    check("resync_os_phase", 32'(bus.os_phase), 32'd9);
    wait_for(1'b1, 1000);
    check("resync_baud_delay", 32'(cyc - t0), 32'd216);

    // Freeze for 100 clocks at pc=12.
    wait_for(1'b0, 100);
    repeat (12) @(negedge clk);
    bus.en = 1'b0;
    ph     = int'(bus.os_phase);
    repeat (100) @(negedge clk);
    check("freeze_phase_held", 32'(bus.os_phase), 32'(ph));
    bus.en = 1'b1;
    t0     = cyc;
    wait_for(1'b0, 100);
    check("freeze_resume_delay", 32'(cyc - t0), 32'd15);

    // Divisor change requested mid-period at pc=5.
    t0 = cyc;
    repeat (5) @(negedge clk);
    pulse_load(16'd10);
    check("load_pending_div", 32'(bus.div_active), 32'd27);
    wait_for(1'b0, 100);
    check("load_period_kept", 32'(cyc - t0), 32'd27);
    check("load_applied_div", 32'(bus.div_active), 32'd10);
    t0 = cyc;
    wait_for(1'b0, 100);
    check("new_period", 32'(cyc - t0), 32'd10);

    // Illegal divisors are rejected.
    pulse_load(16'd1);
    check("err_pulse_1", 32'(bus.div_err), 32'd1);
    check("err_div_kept_1", 32'(bus.div_active), 32'd10);
    @(negedge clk);
    check("err_single_cycle", 32'(bus.div_err), 32'd0);
    pulse_load(16'd0);
    check("err_pulse_0", 32'(bus.div_err), 32'd1);
    wait_for(1'b0, 100);
    t0 = cyc;
    wait_for(1'b0, 100);
    check("err_period_kept", 32'(cyc - t0), 32'd10);

    // Reset with a pending load, a bad load and resync in the same cycle.
    pulse_load(16'd7);
    bus.div_load = 1'b1;
    bus.div_in   = 16'd1;
    bus.resync   = 1'b1;
    rst          = 1'b1;
    @(negedge clk);
    bus.div_load = 1'b0;
    bus.resync   = 1'b0;
    check("rst2_div_active", 32'(bus.div_active), 32'd27);
    check("rst2_os_phase", 32'(bus.os_phase), 32'd0);
    check("rst2_strobes", 32'({bus.os_tick, bus.baud_tick, bus.div_err}), 32'd0);
    rst = 1'b0;
    t0  = cyc;
    wait_for(1'b0, 100);
    check("rst2_first_tick", 32'(cyc - t0), 32'd27);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst          = 1'b0;
      bus.div_load = 1'b0;
      bus.resync   = 1'b0;
      r = int'($urandom_range(0, 999));
      if (r < 2) begin
        rst = 1'b1;
      end else if (r < 8) begin
        bus.resync = 1'b1;
      end else if (bus.en && !m_pend_v && r < 18) begin
        bus.en = 1'b0;
      end else if (!bus.en && r < 60) begin
        bus.en = 1'b1;
      end else if (bus.en && r < 110) begin
        bus.div_load = 1'b1;
        bus.div_in   = DW'($urandom_range(0, 12));
      end
    end
    @(negedge clk);
    rst          = 1'b0;
    bus.div_load = 1'b0;
    bus.resync   = 1'b0;
    bus.en       = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    check("tick_queue_drained", 32'(tick_q.size()), 32'd0);
    check("err_queue_drained", 32'(err_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
